seg7_capture_encoder: RTL
=========================

Name: seg7_capture_encoder

Overview:
- Inverse of the team's BCD-to-7-segment decoder. It samples an external active-low 7-segment bus, for example a HEX output looped from another board through GPIO.
- It filters glitches, recovers the decimal digit 0-9, and presents it on a valid/ready handshake to downstream logic such as a register file loader or the LED display path.
- It flags blank and illegal patterns.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).
STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a pattern is accepted (minimum 1).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
segmentos_in  input  7  asynchronous active-low segment pattern; bit0=a ... bit6=g.
digit_out  output  4  recovered BCD digit; held stable while digit_valid=1.
digit_valid  output  1  digit_out holds an unconsumed digit.
digit_ready  input  1  consumer accepts digit_out on an edge where valid and ready are both 1.
blank  output  1  last accepted pattern was 7'b1111111.
seg_error  output  1  single-cycle pulse: an accepted pattern was neither a digit nor blank.
overrun  output  1  sticky: a digit was accepted while the buffer was still full; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Synchronizer flops load 7'b1111111.
  - Stability counter=0; last-accepted register=7'b1111111; state=S_TRACK.
  - digit_out=0, digit_valid=0, blank=1, seg_error=0, overrun=0.
  - Reset mid-operation discards any pending digit immediately.
- Synchronizer: SYNC_STAGES-deep flop chain on all 7 bits; the chain output is sync_seg.
- Stability filter:
  - The counter increments each edge while sync_seg equals its value on the previous edge, saturating at STABLE_CYCLES.
  - Any difference resets the counter to 0.
- FSM:
  - S_TRACK: when the counter reaches STABLE_CYCLES and sync_seg differs from last-accepted, accept the pattern. Load last-accepted, go to S_HOLD.
  - S_HOLD: the same pattern is never re-accepted. Any change of sync_seg returns to S_TRACK (counter restarts).
  - A bounce back to the previously accepted pattern before it is stable produces no new output.
- Encoding on accept (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Digit match: write the digit into the output buffer and clear blank.
  - 1111111: set blank=1; no digit emitted.
  - Any other pattern: pulse seg_error for exactly one cycle; blank unchanged; no digit emitted.
- Output buffer and handshake (one entry):
  - On accept of a digit with digit_valid=0, or with digit_valid=1 and digit_ready=1 on the same edge: load digit_out and set digit_valid=1.
  - On accept of a digit with digit_valid=1 and digit_ready=0: keep the old digit, drop the new one, set overrun=1.
  - On valid&ready with no new accept: clear digit_valid; digit_out keeps its last value.
  - digit_out must not change while digit_valid=1 and digit_ready=0.
- Latency: the input changes before edge 0 and is held steady. digit_valid rises on edge SYNC_STAGES+STABLE_CYCLES (6 edges with the defaults). blank and seg_error use the same latency.
- Widths: counter is clog2(STABLE_CYCLES+1) bits; there is no arithmetic beyond the counter increment.

Test Plan:
1. Reset, then drive 0100100 steadily with digit_ready=0 -> digit_valid=1 and digit_out=2 exactly 6 edges after the change; blank=0; held for 20 cycles. Then assert ready for 1 cycle -> digit_valid=0 on the next edge.
2. With ready=1, drive 0000010 for 3 cycles, then 1111000 for 10 cycles -> no digit 6 emitted; single digit 7 emitted 6 edges after the second change.
3. With ready=1, drive 0010000 (9), then 1111111, then 0010000 again -> digit 9, then blank=1, then a second digit 9 (re-accept after change); seg_error stays 0 throughout.
4. Drive 0101010 stable -> seg_error high for exactly 1 cycle at edge 6; no digit_valid; blank keeps its prior value.
5. With ready=0, accept 3, then accept 5 -> digit_out stays 3, overrun=1. Assert ready -> 3 consumed, digit_valid=0, overrun remains 1 until reset.
6. Assert rst_n=0 asynchronously (between edges) while digit_valid=1 -> digit_valid=0, blank=1, overrun=0 immediately without a clock edge. Release reset, drive 1111001 -> digit 1 after 6 edges.

Source files
------------

// File: rtl/seg7_capture_encoder.sv
// Recovers a BCD digit from an asynchronous active-low 7-segment bus.
// The input is synchronized and debounced, then presented on a one-entry valid/ready buffer.
module seg7_capture_encoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segmentos_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       blank,
  output logic       seg_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    S_TRACK,
    S_HOLD
  } state_t;

  // Returns {is_digit, digit} for an active-low segment pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b1000000: r = 5'b1_0000;
      7'b1111001: r = 5'b1_0001;
      7'b0100100: r = 5'b1_0010;
      7'b0110000: r = 5'b1_0011;
      7'b0011001: r = 5'b1_0100;
      7'b0010010: r = 5'b1_0101;
      7'b0000010: r = 5'b1_0110;
      7'b1111000: r = 5'b1_0111;
      7'b0000000: r = 5'b1_1000;
      7'b0010000: r = 5'b1_1001;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [6:0]       sync_q [SYNC_STAGES];
  logic [6:0]       sync_seg;
  logic [6:0]       prev_q;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             same;
  logic             accept;
  logic [4:0]       dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SEG_BLANK;
    end else begin
      sync_q[0] <= segmentos_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_seg = sync_q[SYNC_STAGES-1];
  assign same     = (sync_seg == prev_q);
  assign dec      = seg_decode(sync_seg);

  always_comb begin
    cnt_d = '0;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  end

  // Acceptance fires on the edge the counter reaches its target, which keeps
  // the end-to-end latency at SYNC_STAGES + STABLE_CYCLES edges.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_TRACK: begin
        if (cnt_d == CNT_MAX && sync_seg != last_q) begin
          accept  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!same) state_d = S_TRACK;
      end
      default: state_d = S_TRACK;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    digit_d = digit_q;
    valid_d = valid_q;
    blank_d = blank_q;
    ovr_d   = ovr_q;
    err_d   = 1'b0;
    if (valid_q && digit_ready) valid_d = 1'b0;
    if (accept) begin
      last_d = sync_seg;
      if (dec[4]) begin
        blank_d = 1'b0;
        if (!valid_q || digit_ready) begin
          digit_d = dec[3:0];
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (sync_seg == SEG_BLANK) begin
        blank_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= SEG_BLANK;
      last_q  <= SEG_BLANK;
      cnt_q   <= '0;
      state_q <= S_TRACK;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= sync_seg;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign seg_error   = err_q;
  assign overrun     = ovr_q;

endmodule
